pdm_decimator: RTL

Receive-side counterpart of the on-chip PCM-to-PDM modulator: accepts a 1-bit PDM stream and recovers unsigned 16-bit PCM samples. It uses a 2nd-order CIC (sinc²) decimation filter with ratio R = 2^DECIM_LOG2. It sits between a PDM source and downstream PCM consumers, either an external microphone or the internal modulator output in loopback. Its output format matches the modulator's input: unsigned, 0x0000 = minimum, 0xFFFF = full scale.

---
 rtl/pdm_decimator_if.sv | 31 +++
 rtl/pdm_decimator.sv | 111 +++++++++++
 2 files changed

// File: rtl/pdm_decimator_if.sv
// pdm_decimator_if
//   Bundles the PDM input stream and the decimated PCM output of the
//   pdm_decimator so that producer and consumer share one connection.
//   Signals:
//     pdm_in     1-bit PDM data, meaningful only when pdm_valid=1
//     pdm_valid  one PDM bit consumed per clk cycle with pdm_valid=1
//     pcm_out    unsigned 16-bit decimated sample, held between updates
//     pcm_valid  one-cycle pulse marking a new pcm_out value
//   Modports:
//     slave   the decimator (consumes PDM, produces PCM)
//     master  the PDM source / PCM consumer side
interface pdm_decimator_if;
    logic        pdm_in;
    logic        pdm_valid;
    logic [15:0] pcm_out;
    logic        pcm_valid;

    modport slave (
        input  pdm_in,
        input  pdm_valid,
        output pcm_out,
        output pcm_valid
    );

    modport master (
        output pdm_in,
        output pdm_valid,
        input  pcm_out,
        input  pcm_valid
    );
endinterface

// File: rtl/pdm_decimator.sv
// pdm_decimator
//   Recovers unsigned 16-bit PCM from a 1-bit PDM stream using a
//   2nd-order CIC (sinc^2) decimator with ratio R = 2**DECIM_LOG2.
//   Output format: 0x0000 = minimum, 0xFFFF = full scale.
//   Ports:
//     clk    single system clock, rising edge
//     rst_n  asynchronous active-low reset, clears all state
//     bus    pdm_decimator_if.slave: pdm_in/pdm_valid in,
//            pcm_out/pcm_valid out
//   Pipeline: the edge that samples the R-th strobe of a frame updates
//   the integrators and flags the frame; the following edge runs the
//   comb stages on the settled integrator value and registers pcm_out.
module pdm_decimator #(
    parameter int DECIM_LOG2 = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    pdm_decimator_if.slave  bus
);

    localparam int W     = 2 * DECIM_LOG2 + 1;
    localparam int SHIFT = 16 - 2 * DECIM_LOG2;
    localparam logic [DECIM_LOG2-1:0] CNT_ONE = {{(DECIM_LOG2-1){1'b0}}, 1'b1};

    generate
        if ((DECIM_LOG2 < 4) || (DECIM_LOG2 > 8)) begin : g_bad_decim
            $error("pdm_decimator: DECIM_LOG2 must be within 4..8");
        end
    endgenerate

    // Integrators, comb history and frame counter; all arithmetic wraps mod 2**W.
    logic [W-1:0]          i1_q, i1_d;
    logic [W-1:0]          i2_q, i2_d;
    logic [W-1:0]          s_prev_q, s_prev_d;
    logic [W-1:0]          c1_prev_q, c1_prev_d;
    logic [DECIM_LOG2-1:0] cnt_q, cnt_d;
    logic                  frame_q, frame_d;
    logic [15:0]           pcm_q, pcm_d;
    logic                  pcm_valid_q, pcm_valid_d;

    logic [W-1:0]          c1_s;
    logic [W-1:0]          c2_s;
    logic [15:0]           y_ext_s;

    // Next-state logic: integrator/counter update on strobes, comb on frame end.
    always_comb begin
        i1_d        = i1_q;
        i2_d        = i2_q;
        s_prev_d    = s_prev_q;
        c1_prev_d   = c1_prev_q;
        cnt_d       = cnt_q;
        frame_d     = 1'b0;
        pcm_d       = pcm_q;
        pcm_valid_d = 1'b0;

        // While frame_q is set, i2_q holds s (the value after the frame's last strobe).
        c1_s    = i2_q - s_prev_q;
        c2_s    = c1_s - c1_prev_q;
        // c2 never exceeds R**2, so only R**2 itself sets the top bit.
        y_ext_s = 16'(c2_s[W-2:0]);

        if (bus.pdm_valid) begin
            i1_d    = i1_q + {{(W-1){1'b0}}, bus.pdm_in};
            i2_d    = i2_q + i1_d;
            cnt_d   = cnt_q + CNT_ONE;
            frame_d = &cnt_q;
        end else begin
            frame_d = 1'b0;
        end

        if (frame_q) begin
            s_prev_d    = i2_q;
            c1_prev_d   = c1_s;
            pcm_valid_d = 1'b1;
            if (c2_s[W-1]) begin
                pcm_d = 16'hFFFF;
            end else begin
                pcm_d = y_ext_s << SHIFT;
            end
        end else begin
            pcm_valid_d = 1'b0;
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i1_q        <= '0;
            i2_q        <= '0;
            s_prev_q    <= '0;
            c1_prev_q   <= '0;
            cnt_q       <= '0;
            frame_q     <= 1'b0;
            pcm_q       <= 16'h0000;
            pcm_valid_q <= 1'b0;
        end else begin
            i1_q        <= i1_d;
            i2_q        <= i2_d;
            s_prev_q    <= s_prev_d;
            c1_prev_q   <= c1_prev_d;
            cnt_q       <= cnt_d;
            frame_q     <= frame_d;
            pcm_q       <= pcm_d;
            pcm_valid_q <= pcm_valid_d;
        end
    end

    assign bus.pcm_out   = pcm_q;
    assign bus.pcm_valid = pcm_valid_q;

endmodule
